// File: rtl/gpk_pkg.sv
// Shared generate/propagate/kill types and helpers for the prefix adder.
package gpk_pkg;

    // Per-position carry status. Encoding 2'b10 is illegal and never produced.
    typedef logic [1:0] gpk_t;

    localparam gpk_t GPK_K = 2'b00;
    localparam gpk_t GPK_P = 2'b01;
    localparam gpk_t GPK_G = 2'b11;

    // Prefix operator: a propagating upper span defers to the lower span.
    function automatic gpk_t gpk_combine(input gpk_t upper, input gpk_t lower);
        return (upper == GPK_P) ? lower : upper;
    endfunction

    // Single-bit GPK from operand bits: {a&b, a|b} yields K=00, P=01, G=11.
    function automatic gpk_t gpk_encode(input logic a, input logic b);
        return {a & b, a | b};
    endfunction

    // Ceiling log2 for elaboration-time sizing.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/gpk_level.sv
// One registered Kogge-Stone prefix level: position j combines with j-DIST.
// Index 0 of the GPK vector is the carry-in (bit position -1).
module gpk_level
    import gpk_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIST  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             in_valid,
    input  gpk_t [WIDTH:0]   in_gpk,
    input  logic [WIDTH-1:0] in_half,
    output logic             out_valid,
    output gpk_t [WIDTH:0]   out_gpk,
    output logic [WIDTH-1:0] out_half
);

    gpk_t [WIDTH:0] next_gpk;

    for (genvar j = 0; j <= WIDTH; j++) begin : g_pos
        if (j >= DIST) begin : g_comb
            assign next_gpk[j] = gpk_combine(in_gpk[j], in_gpk[j-DIST]);
        end else begin : g_pass
            assign next_gpk[j] = in_gpk[j];
        end
    end

    // Stage valid bit: cleared asynchronously, advances with the global enable.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
        end else if (en) begin
            out_valid <= in_valid;
        end
    end

    // Prefix payload; its content is ignored whenever out_valid is low.
    // NOTE: payload registers are deliberately not reset; the valid bit alone qualifies them.
    always_ff @(posedge clk) begin
        if (en) begin
            out_gpk  <= next_gpk;
            out_half <= in_half;
        end
    end

endmodule

// File: rtl/pipelined_gpk_adder.sv
// Streaming pipelined GPK prefix adder/subtractor with carry-out and signed overflow.
// Pipeline: stage 0 (operand prep), log2(WIDTH) prefix levels, registered result.
module pipelined_gpk_adder
    import gpk_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int LEVELS = clog2(WIDTH);

    logic                          en;
    logic [WIDTH-1:0]              b_eff;
    logic                          c0;
    gpk_t [WIDTH:0]                init_gpk;
    logic [WIDTH-1:0]              init_half;

    logic                          s0_valid;
    gpk_t [WIDTH:0]                s0_gpk;
    logic [WIDTH-1:0]              s0_half;

    logic [LEVELS:0]               lvl_valid;
    gpk_t [LEVELS:0][WIDTH:0]      lvl_gpk;
    logic [LEVELS:0][WIDTH-1:0]    lvl_half;

    gpk_t [WIDTH:0]                fin_gpk;
    logic [WIDTH-1:0]              fin_half;
    gpk_t                          top_span;
    logic                          carry_msb;
    logic [WIDTH-1:0]              next_sum;
    logic                          next_cout;
    logic                          next_ovf;

    // Global stall: everything advances only when the output slot is free or draining.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // Operand preparation and per-bit GPK encoding; slot 0 holds the carry-in.
    always_comb begin
        b_eff       = in_sub ? ~in_b : in_b;
        c0          = in_sub | in_cin;
        init_half   = in_a ^ b_eff;
        init_gpk[0] = c0 ? GPK_G : GPK_K;
        for (int i = 0; i < WIDTH; i++) begin
            init_gpk[i+1] = gpk_encode(in_a[i], b_eff[i]);
        end
    end

    // Stage 0 valid bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s0_valid <= 1'b0;
        end else if (en) begin
            s0_valid <= in_valid;
        end
    end

    // Stage 0 payload.
    always_ff @(posedge clk) begin
        if (en) begin
            s0_gpk  <= init_gpk;
            s0_half <= init_half;
        end
    end

    assign lvl_valid[0] = s0_valid;
    assign lvl_gpk[0]   = s0_gpk;
    assign lvl_half[0]  = s0_half;

    for (genvar k = 0; k < LEVELS; k++) begin : g_level
        gpk_level #(
            .WIDTH (WIDTH),
            .DIST  (1 << k)
        ) u_level (
            .clk       (clk),
            .reset     (reset),
            .en        (en),
            .in_valid  (lvl_valid[k]),
            .in_gpk    (lvl_gpk[k]),
            .in_half   (lvl_half[k]),
            .out_valid (lvl_valid[k+1]),
            .out_gpk   (lvl_gpk[k+1]),
            .out_half  (lvl_half[k+1])
        );
    end

    assign fin_gpk  = lvl_gpk[LEVELS];
    assign fin_half = lvl_half[LEVELS];

    // Carry extraction and result forming; bubbles produce all-zero results.
    // The top position's span after log2(WIDTH) levels reaches bit 0 but not the
    // carry-in slot, so the carry-in is folded in here for the carry-out.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        next_sum  = '0;
        next_cout = 1'b0;
        next_ovf  = 1'b0;
        carry_msb = 1'b0;
        top_span  = gpk_combine(fin_gpk[WIDTH], fin_gpk[0]);
        if (lvl_valid[LEVELS]) begin
            for (int i = 0; i < WIDTH; i++) begin
                next_sum[i] = fin_half[i] ^ (fin_gpk[i] == GPK_G);
            end
            carry_msb = (fin_gpk[WIDTH-1] == GPK_G);
            next_cout = (top_span == GPK_G);
            next_ovf  = carry_msb ^ next_cout;
        end
    end

    // Output register: fully reset so idle outputs read zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            out_ovf   <= 1'b0;
        end else if (en) begin
            out_valid <= lvl_valid[LEVELS];
            out_sum   <= next_sum;
            out_cout  <= next_cout;
            out_ovf   <= next_ovf;
        end
    end

endmodule

// File: tb/tb_pipelined_gpk_adder.sv
// Scoreboard bench for pipelined_gpk_adder at WIDTH 8, 16 and 32.
module tb_pipelined_gpk_adder;

    localparam int NDUT = 3;

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid  [NDUT];
    logic        in_ready  [NDUT];
    logic [31:0] in_a      [NDUT];
    logic [31:0] in_b      [NDUT];
    logic        in_cin    [NDUT];
    logic        in_sub    [NDUT];
    logic        out_valid [NDUT];
    logic        out_ready [NDUT];
    logic [31:0] out_sum   [NDUT];
    logic        out_cout  [NDUT];
    logic        out_ovf   [NDUT];
    logic [7:0]  sum8;
    logic [15:0] sum16;
    logic [31:0] sum32;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    logic prev_stall [NDUT];
    exp_t prev_out   [NDUT];
    logic saw_block = 1'b0;
    int   n_done = 0;

    always #5 clk = ~clk;

    pipelined_gpk_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_a(in_a[0][7:0]), .in_b(in_b[0][7:0]), .in_cin(in_cin[0]), .in_sub(in_sub[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_sum(sum8), .out_cout(out_cout[0]), .out_ovf(out_ovf[0])
    );

    pipelined_gpk_adder #(.WIDTH(16)) u_dut16 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_a(in_a[1][15:0]), .in_b(in_b[1][15:0]), .in_cin(in_cin[1]), .in_sub(in_sub[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_sum(sum16), .out_cout(out_cout[1]), .out_ovf(out_ovf[1])
    );

    pipelined_gpk_adder #(.WIDTH(32)) u_dut32 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_a(in_a[2]), .in_b(in_b[2]), .in_cin(in_cin[2]), .in_sub(in_sub[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .out_sum(sum32), .out_cout(out_cout[2]), .out_ovf(out_ovf[2])
    );

    assign out_sum[0] = {24'd0, sum8};
    assign out_sum[1] = {16'd0, sum16};
    assign out_sum[2] = sum32;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] sum, input logic cout, input logic ovf);
        exp_t e;
        e.sum  = sum;
        e.cout = cout;
        e.ovf  = ovf;
        return e;
    endfunction

    // Integer reference: unsigned sum for result/carry, signed sum for overflow.
    function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                   input logic cin, input logic sub);
        longint md, ua, ub, sa, sb, full, sres;
        exp_t   e;
        md = longint'(1) << w;
        ua = longint'(a) & (md - 1);
        ub = longint'(b) & (md - 1);
        sa = (ua >= md / 2) ? ua - md : ua;
        sb = (ub >= md / 2) ? ub - md : ub;
        if (sub) begin
            full   = ua - ub;
            sres   = sa - sb;
            e.cout = (ua >= ub);
        end else begin
            full   = ua + ub + (cin ? 1 : 0);
            sres   = sa + sb + (cin ? 1 : 0);
            e.cout = (full >= md);
        end
        e.sum = 32'(full & (md - 1));
        e.ovf = (sres < -(md / 2)) || (sres >= md / 2);
        return e;
    endfunction

    function automatic int qsize(input int d);
        case (d)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic push(input int d, input exp_t e);
        case (d)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    function automatic exp_t pop(input int d);
        case (d)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    // Monitor: protocol checks every cycle, scoreboard compare on each consumed result.
    task automatic monitor_one(input int d);
        exp_t cur;
        exp_t e;
        cur = mk(out_sum[d], out_cout[d], out_ovf[d]);
        check($sformatf("dut%0d in_ready", d), in_ready[d], !out_valid[d] || out_ready[d]);
        if (prev_stall[d]) begin
            check($sformatf("dut%0d stall holds valid", d), out_valid[d], 1'b1);
            check($sformatf("dut%0d stall holds data", d), cur, prev_out[d]);
        end
        if (!out_valid[d]) begin
            check($sformatf("dut%0d idle outputs zero", d), cur, '0);
        end else if (out_ready[d]) begin
            check($sformatf("dut%0d result expected", d), qsize(d) != 0, 1'b1);
            if (qsize(d) != 0) begin
                e = pop(d);
                check($sformatf("dut%0d sum", d), cur.sum, e.sum);
                check($sformatf("dut%0d cout", d), cur.cout, e.cout);
                check($sformatf("dut%0d ovf", d), cur.ovf, e.ovf);
            end
        end
        if (d == 0 && out_valid[d] && !out_ready[d] && !in_ready[d]) saw_block = 1'b1;
        prev_stall[d] = out_valid[d] && !out_ready[d];
        prev_out[d]   = cur;
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < NDUT; d++) begin
            if (reset) prev_stall[d] = 1'b0;
            else       monitor_one(d);
        end
    end

    // Drive one beat; waits for in_ready, pushes the expectation on the accepting edge.
    task automatic send(input int d, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic sub, input exp_t e);
        int waited;
        waited      = 0;
        in_a[d]     = a;
        in_b[d]     = b;
        in_cin[d]   = cin;
        in_sub[d]   = sub;
        in_valid[d] = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready[d]) break;
            waited++;
            if (waited > 200) begin
                n_checks++;
                n_errors++;
                $display("FAIL dut%0d accept timeout: in_ready low for %0d cycles, expected high", d, waited);
                in_valid[d] = 1'b0;
                return;
            end
        end
        @(posedge clk);
        push(d, e);
        #1;
    endtask

    task automatic idle(input int d, input int n);
        in_valid[d] = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((qsize(0) + qsize(1) + qsize(2)) != 0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("dut%0d scoreboard drained", d), qsize(d), 0);
        end
    endtask

    task automatic run_random(input int d, input int w, input int n);
        logic [31:0] mask;
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        for (int i = 0; i < n; i++) begin
            a   = $urandom & mask;
            b   = $urandom & mask;
            cin = 1'($urandom_range(0, 1));
            sub = 1'($urandom_range(0, 1));
            send(d, a, b, cin, sub, model(w, a, b, cin, sub));
            if ($urandom_range(0, 3) == 0) idle(d, $urandom_range(1, 2));
        end
        in_valid[d] = 1'b0;
        n_done++;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [7:0] a8;
        logic [7:0] b8;
        logic       c8;
        logic       s8;

        reset = 1'b1;
        for (int d = 0; d < NDUT; d++) begin
            in_valid[d]   = 1'b0;
            in_a[d]       = '0;
            in_b[d]       = '0;
            in_cin[d]     = 1'b0;
            in_sub[d]     = 1'b0;
            out_ready[d]  = 1'b1;
            prev_stall[d] = 1'b0;
            prev_out[d]   = '0;
        end

        // Reset state.
        #2;
        check("reset out_valid", out_valid[0], 1'b0);
        check("reset out_sum", out_sum[0], 32'd0);
        check("reset out_cout/ovf", {out_cout[0], out_ovf[0]}, 2'b00);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("empty pipe in_ready", in_ready[0], 1'b1);
        @(posedge clk);
        #1;

        // Latency: the accepting edge is the first of the five register stages.
        in_a[0] = 32'h01; in_b[0] = 32'hFE; in_cin[0] = 1'b0; in_sub[0] = 1'b0;
        in_valid[0] = 1'b1;
        @(negedge clk);
        check("latency beat ready", in_ready[0], 1'b1);
        @(posedge clk);
        push(0, mk(32'hFF, 1'b0, 1'b0));
        #1 in_valid[0] = 1'b0;
        n = 1;
        while (!out_valid[0] && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("latency edges", n, 5);
        idle(0, 3);

        // Directed corner cases, back to back.
        send(0, 32'hA7, 32'h03, 1'b0, 1'b0, mk(32'hAA, 1'b0, 1'b0));
        send(0, 32'hFF, 32'h01, 1'b0, 1'b0, mk(32'h00, 1'b1, 1'b0));
        send(0, 32'h7F, 32'h01, 1'b0, 1'b0, mk(32'h80, 1'b0, 1'b1));
        send(0, 32'h81, 32'h07, 1'b0, 1'b1, mk(32'h7A, 1'b1, 1'b1));
        send(0, 32'h05, 32'h07, 1'b0, 1'b1, mk(32'hFE, 1'b0, 1'b0));
        send(0, 32'hFF, 32'h00, 1'b1, 1'b0, mk(32'h00, 1'b1, 1'b0));
        send(0, 32'h10, 32'h10, 1'b1, 1'b1, mk(32'h00, 1'b1, 1'b0));
        send(0, 32'h80, 32'h80, 1'b0, 1'b0, mk(32'h00, 1'b1, 1'b1));
        idle(0, 1);
        drain(40);

        // Stream of 20 beats with the consumer stalled for cycles 3..7.
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    a8 = 8'($urandom);
                    b8 = 8'($urandom);
                    c8 = 1'($urandom_range(0, 1));
                    s8 = 1'($urandom_range(0, 1));
                    send(0, {24'd0, a8}, {24'd0, b8}, c8, s8, model(8, {24'd0, a8}, {24'd0, b8}, c8, s8));
                end
                in_valid[0] = 1'b0;
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready[0] = 1'b0;
                repeat (5) @(posedge clk);
                #1 out_ready[0] = 1'b1;
            end
        join
        drain(60);
        check("in_ready low while stalled", saw_block, 1'b1);

        // Asynchronous reset with three beats in flight.
        out_ready[0] = 1'b0;
        send(0, 32'h11, 32'h22, 1'b0, 1'b0, mk(32'h33, 1'b0, 1'b0));
        send(0, 32'h44, 32'h55, 1'b0, 1'b0, mk(32'h99, 1'b0, 1'b1));
        send(0, 32'hF0, 32'h0F, 1'b1, 1'b0, mk(32'h00, 1'b1, 1'b0));
        in_valid[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("pre-reset out_valid", out_valid[0], 1'b1);
        @(negedge clk);
        #2 reset = 1'b1;
        q0.delete();
        q1.delete();
        q2.delete();
        #1;
        check("async reset out_valid", out_valid[0], 1'b0);
        check("async reset out_sum", out_sum[0], 32'd0);
        check("async reset out_cout/ovf", {out_cout[0], out_ovf[0]}, 2'b00);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        out_ready[0] = 1'b1;
        repeat (12) begin
            @(negedge clk);
            check("no stale beat after reset", out_valid[0], 1'b0);
        end
        @(posedge clk);
        #1;

        // Random streams on all widths with random consumer back-pressure.
        fork
            run_random(0, 8, 3000);
            run_random(1, 16, 10000);
            run_random(2, 32, 10000);
            begin
                while (n_done < NDUT) begin
                    for (int d = 0; d < NDUT; d++) out_ready[d] = ($urandom_range(0, 3) != 0);
                    @(posedge clk);
                    #1;
                end
            end
        join
        for (int d = 0; d < NDUT; d++) out_ready[d] = 1'b1;
        drain(100);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
